// File: rtl/calc_op_sequencer_pkg.sv
// Shared types and constants for the calculator operation sequencer.
// Opcode and state encodings are fixed here so the front end and bench agree.
package calc_pkg;

    localparam int CALC_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ITER = 2'b10,
        DONE = 2'b11
    } seq_state_t;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Request/result bundle between the operand front end and the sequencer.
// The front end is the master; the sequencer is the slave.
interface calc_op_sequencer_if
    import calc_pkg::*;
#(
    parameter int W = CALC_W
);

    logic         start;
    op_t          op;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         ovr;
    logic         dz;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, result_lo, result_hi, carry, ovr, dz
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, result_lo, result_hi, carry, ovr, dz
    );

endinterface

// File: rtl/calc_op_sequencer.sv
// Multi-cycle ADD/SUB/MUL/DIV controller that time-shares one external add/sub
// unit: MUL is shift-add, DIV is restoring division, one adder use per cycle.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int W     = CALC_W,
    parameter int ITERS = CALC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    calc_op_sequencer_if.slave       bus,
    output logic [W-1:0]             add_a,
    output logic [W-1:0]             add_b,
    output logic                     add_sub,
    input  logic [W-1:0]             add_r,
    input  logic                     add_cout
);

    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    seq_state_t   state_q, state_d;
    op_t          op_q, op_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] opd_q, opd_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [W-1:0] res_lo_q, res_lo_d;
    logic [W-1:0] res_hi_q, res_hi_d;
    logic         carry_q, carry_d;
    logic         ovr_q, ovr_d;
    logic         dz_q, dz_d;

    logic         mul_c;
    logic [W-1:0] mul_p;
    logic         div_msb;
    logic [W-1:0] div_rs;
    logic         div_ge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            acc_q    <= '0;
            quo_q    <= '0;
            opd_q    <= '0;
            cnt_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            carry_q  <= 1'b0;
            ovr_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            opd_q    <= opd_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            carry_q  <= carry_d;
            ovr_q    <= ovr_d;
            dz_q     <= dz_d;
        end
    end

    // quo holds A (multiplier / dividend), opd holds B, acc is P or R.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        opd_d    = opd_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        carry_d  = carry_q;
        ovr_d    = ovr_q;
        dz_d     = dz_q;
        add_a    = '0;
        add_b    = '0;
        add_sub  = 1'b0;
        mul_c    = 1'b0;
        mul_p    = '0;
        div_msb  = 1'b0;
        div_rs   = '0;
        div_ge   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    quo_d = bus.a_in;
                    opd_d = bus.b_in;
                    acc_d = '0;
                    cnt_d = '0;
                    state_d = (bus.op == OP_MUL || bus.op == OP_DIV) ? ITER : EXEC;
                end
            end
            EXEC: begin
                // SUB feeds B as add_a so the adder's b-a yields A-B.
                if (op_q == OP_SUB) begin
                    add_a   = opd_q;
                    add_b   = quo_q;
                    add_sub = 1'b1;
                    carry_d = add_cout && (quo_q != opd_q);
                    ovr_d   = (quo_q[W-1] != opd_q[W-1]) && (add_r[W-1] != quo_q[W-1]);
                end else begin
                    add_a   = quo_q;
                    add_b   = opd_q;
                    carry_d = add_cout;
                    ovr_d   = (quo_q[W-1] == opd_q[W-1]) && (add_r[W-1] != quo_q[W-1]);
                end
                res_lo_d = add_r;
                res_hi_d = '0;
                dz_d     = 1'b0;
                state_d  = DONE;
            end
            ITER: begin
                if (op_q == OP_MUL) begin
                    add_a = opd_q;
                    add_b = acc_q;
                    {mul_c, mul_p} = quo_q[0] ? {add_cout, add_r} : {1'b0, acc_q};
                    acc_d = {mul_c, mul_p[W-1:1]};
                    quo_d = {mul_p[0], quo_q[W-1:1]};
                end else begin
                    {div_msb, div_rs} = {acc_q, quo_q[W-1]};
                    add_a   = opd_q;
                    add_b   = div_rs;
                    add_sub = 1'b1;
                    div_ge  = div_msb || !add_cout || (div_rs == opd_q);
                    acc_d   = div_ge ? add_r : div_rs;
                    quo_d   = {quo_q[W-2:0], div_ge};
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    res_lo_d = quo_d;
                    res_hi_d = acc_d;
                    carry_d  = 1'b0;
                    ovr_d    = (op_q == OP_MUL) && (acc_d != '0);
                    dz_d     = (op_q == OP_DIV) && (opd_q == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.carry     = carry_q;
    assign bus.ovr       = ovr_q;
    assign bus.dz        = dz_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a behavioural adder and a
// scoreboard of arithmetic results computed directly from the operands.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       carry;
        logic       ovr;
        logic       dz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] add_a, add_b, add_r;
    logic       add_sub, add_cout;

    int   checks   = 0;
    int   failures = 0;
    int   doneSeen;
    exp_t sbQ[$];
    exp_t lastExp;
    op_t  rOp;

    always #5 clk = ~clk;

    calc_op_sequencer_if #(.W(8)) bus ();

    calc_op_sequencer #(.W(8), .ITERS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sub  (add_sub),
        .add_r    (add_r),
        .add_cout (add_cout)
    );

    // Behavioural model of the external shared add/sub unit.
    assign add_r    = add_sub ? (add_b - add_a) : (add_a + add_b);
    assign add_cout = add_sub ? (add_a >= add_b) : ((9'(add_a) + 9'(add_b)) > 9'd255);

    function automatic exp_t model(op_t op, logic [7:0] a, logic [7:0] b);
        exp_t e;
        logic [8:0]  s;
        logic [15:0] p;
        e = '0;
        case (op)
            OP_ADD: begin
                s = 9'(a) + 9'(b);
                e.lo = s[7:0];
                e.carry = s[8];
                e.ovr = (a[7] == b[7]) && (s[7] != a[7]);
            end
            OP_SUB: begin
                e.lo = a - b;
                e.carry = (a < b);
                e.ovr = (a[7] != b[7]) && (e.lo[7] != a[7]);
            end
            OP_MUL: begin
                p = 16'(a) * 16'(b);
                e.lo = p[7:0];
                e.hi = p[15:8];
                e.ovr = (p > 16'd255);
            end
            default: begin
                if (b == 8'd0) begin
                    e.lo = 8'hFF;
                    e.hi = a;
                    e.dz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("[TB] %s check did not hold", tag);
        end
    endtask

    task automatic checkReset(string tag);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_lo"}, 32'(bus.result_lo), 32'd0);
        checkOutput({tag, "_hi"}, 32'(bus.result_hi), 32'd0);
        checkOutput({tag, "_flags"}, 32'({bus.carry, bus.ovr, bus.dz}), 32'd0);
        checkOutput({tag, "_adder"}, 32'({add_a, add_b, add_sub}), 32'd0);
    endtask

    // Drives one start pulse, scores it, and returns in cycle 1 after acceptance.
    task automatic applyStimulus(op_t op, logic [7:0] a, logic [7:0] b);
        @(negedge clk);
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.start = 1'b1;
        sbQ.push_back(model(op, a, b));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
        bus.op    = op_t'(~op);
        checkOutput("busy_c1", 32'(bus.busy), 32'd1);
    endtask

    task automatic waitDone(string tag, int expCycle, bit poke);
        int cycle;
        cycle = 1;
        while (!bus.done && cycle < 40) begin
            bus.start = poke && (cycle >= 3) && (cycle <= 5);
            if (poke) checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
            @(posedge clk);
            cycle++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
        checkOutput({tag, "_lat"}, 32'(cycle), 32'(expCycle));
        checkOutput({tag, "_sbq"}, 32'(sbQ.size()), 32'd1);
        if (sbQ.size() > 0) begin
            lastExp = sbQ.pop_front();
            checkOutput({tag, "_lo"}, 32'(bus.result_lo), 32'(lastExp.lo));
            checkOutput({tag, "_hi"}, 32'(bus.result_hi), 32'(lastExp.hi));
            checkOutput({tag, "_carry"}, 32'(bus.carry), 32'(lastExp.carry));
            checkOutput({tag, "_ovr"}, 32'(bus.ovr), 32'(lastExp.ovr));
            checkOutput({tag, "_dz"}, 32'(bus.dz), 32'(lastExp.dz));
        end
    endtask

    task automatic checkHold(string tag);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_res"}, 32'({bus.result_hi, bus.result_lo}), 32'({lastExp.hi, lastExp.lo}));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.a_in  = '0;
        bus.b_in  = '0;
        rst_n     = 1'b0;
        #2;
        checkReset("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_ADD, 8'd200, 8'd100);
        waitDone("add_200_100", 2, 1'b0);
        checkHold("add_hold");
        applyStimulus(OP_ADD, 8'd100, 8'd100);
        waitDone("add_100_100", 2, 1'b0);
        applyStimulus(OP_SUB, 8'd5, 8'd9);
        waitDone("sub_5_9", 2, 1'b0);
        applyStimulus(OP_SUB, 8'd9, 8'd9);
        waitDone("sub_9_9", 2, 1'b0);

        applyStimulus(OP_MUL, 8'd25, 8'd13);
        waitDone("mul_25_13", 9, 1'b1);
        checkHold("mul_ignore_start");
        checkHold("mul_hold2");
        applyStimulus(OP_MUL, 8'd255, 8'd255);
        waitDone("mul_255_255", 9, 1'b0);

        applyStimulus(OP_DIV, 8'd200, 8'd7);
        waitDone("div_200_7", 9, 1'b0);
        applyStimulus(OP_DIV, 8'd255, 8'd1);
        waitDone("div_255_1", 9, 1'b0);
        applyStimulus(OP_DIV, 8'd77, 8'd0);
        waitDone("div_77_0", 9, 1'b0);
        checkHold("div_hold");

        for (int i = 0; i < 6; i++) begin
            rOp = op_t'($urandom_range(0, 3));
            applyStimulus(rOp, 8'($urandom), 8'($urandom));
            waitDone("rand", (rOp == OP_ADD || rOp == OP_SUB) ? 2 : 9, 1'b0);
        end

        // Reset in cycle 4 of a DIV must clear everything at once.
        applyStimulus(OP_DIV, 8'd200, 8'd7);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkReset("rst_mid_div");
        if (sbQ.size() > 0) lastExp = sbQ.pop_front();
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("rst_no_done", 32'(doneSeen), 32'd0);
        checkOutput("rst_idle_busy", 32'(bus.busy), 32'd0);

        applyStimulus(OP_ADD, 8'd100, 8'd27);
        waitDone("add_after_rst", 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Multi-cycle controller that executes all four calculator operations (ADD, SUB, MUL, DIV) on 8-bit unsigned operands. It time-shares the single external 8-bit group-carry-lookahead add/sub unit. It sits between the operand/opcode front end and the display path, running MUL as shift-add and DIV as restoring division, one adder use per cycle. Start/busy/done handshake; results are held until the next accepted start.

## Interface
- `W`, 8: operand width (only 8 is supported).
- `ITERS`, 8: MUL/DIV iteration count; must equal `W`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  opcode: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- `a_in`, `b_in`  in  8  operands; captured on the accepted start edge.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle pulse; results valid from this cycle on.
- `result_lo`  out  8  sum/difference, product low byte, or quotient.
- `result_hi`  out  8  0 for ADD/SUB, product high byte, or remainder.
- `carry`  out  1  ADD: carry out. SUB: borrow (a<b). MUL/DIV: 0.
- `ovr`  out  1  ADD/SUB: signed overflow. MUL: product > 255. DIV: 0.
- `dz`  out  1  DIV with `b_in` = 0.
- `add_a`, `add_b`  out  8  operands driven to the shared adder.
- `add_sub`  out  1  adder mode.
- `add_r`  in  8  adder result, combinational.
- `add_cout`  in  1  adder carry, combinational.

## Operation
- **Adder contract:**
  - `add_sub`=0: `add_r` = a+b mod 256, `add_cout` = carry.
  - `add_sub`=1: `add_r` = b−a mod 256, `add_cout` = 1 iff a ≥ b (unsigned).
- **States:** IDLE, EXEC, ITER, DONE.
  - IDLE: `start`=1 captures `op`, A, B. ADD/SUB go to EXEC. MUL/DIV go to ITER, with the counter cleared.
  - EXEC: presents the adder, then goes to DONE.
  - ITER: runs 8 cycles, then goes to DONE.
  - DONE: `done`=1, then returns to IDLE.
- **ADD:**
  - Adder gets `add_a`=A, `add_b`=B, `add_sub`=0.
  - `result_lo` = `add_r`; `carry` = `add_cout`.
  - `ovr` = (A7==B7) && (r7!=A7).
- **SUB:**
  - Adder gets `add_a`=B, `add_b`=A, `add_sub`=1, so `add_r` = A−B.
  - `carry` = `add_cout` && (A!=B).
  - `ovr` = (A7!=B7) && (r7!=A7).
- **MUL:**
  - Registers: P=0 (high byte), Q=A (multiplier), M=B (multiplicand).
  - Each iteration the adder gets `add_a`=M, `add_b`=P, `add_sub`=0.
  - c,P' = Q[0] ? {`add_cout`,`add_r`} : {0,P}.
  - Shift: P <= {c,P'[7:1]}, Q <= {P'[0],Q[7:1]}.
  - At the end: `result_hi`=P, `result_lo`=Q, `ovr` = (P!=0).
- **DIV:**
  - Registers: R=0 (partial remainder), Q=A (dividend/quotient), D=B (divisor).
  - Each iteration: {msb,rs} = {R,Q[7]}. The adder gets `add_a`=D, `add_b`=rs, `add_sub`=1.
  - ge = msb || !`add_cout` || (rs==D).
  - R <= ge ? `add_r` : rs. Q <= {Q[6:0],ge}.
  - At the end: `result_lo`=Q, `result_hi`=R.
- **Divide by zero:** runs normally. Yields quotient 0xFF and remainder = A, with `dz`=1.
- **Adder drive outside EXEC/ITER:** `add_a`=`add_b`=0, `add_sub`=0.
- **Busy behaviour:** `start` while busy is ignored, with no queuing. `op`/`a_in`/`b_in` changes after capture have no effect.
- **Flag update:** all result and flag registers update only at completion. They hold their values through IDLE.

## Timing
- Accepted start on edge 0.
- ADD/SUB: EXEC in cycle 1, `done` in cycle 2. Total latency 2.
- MUL/DIV: ITER in cycles 1–8, `done` in cycle 9. Total latency 9.
- Earliest back-to-back start is the edge that ends the DONE cycle +1, i.e. the first IDLE cycle.
- **Reset values:** state IDLE; all outputs 0, including `busy`, `done`, results, flags and adder drives.
- **Reset mid-operation:** aborts immediately and asynchronously. No `done` is produced, and the previous results are cleared to 0.
- **Critical path:** the adder path `add_r`/`add_cout` → ge/c → register, which must close in one cycle.

## Structure
- **Package `calc_pkg`:**
  - `op_t` enum: ADD, SUB, MUL, DIV.
  - `seq_state_t` enum: IDLE, EXEC, ITER, DONE.
  - Constant `CALC_W`=8.
- **Module layout:** one module with a 3-bit iteration counter. The add/sub unit stays outside and is wired by the parent. No sub-module.

## Test plan
- **ADD:** 200+100 → `result_lo`=0x2C, `carry`=1, `ovr`=0, `done` in cycle 2. Also 100+100 → 0xC8, `ovr`=1.
- **SUB:** 5−9 → `result_lo`=0xFC, `carry`=1. Also 9−9 → 0x00, `carry`=0.
- **MUL:** 25×13 → `result_hi`=0x01, `result_lo`=0x45, `ovr`=1, `done` in cycle 9. Also 255×255 → 0xFE01.
- **DIV:** 200/7 → `result_lo`=0x1C, `result_hi`=0x04. Also 255/1 → 0xFF r 0. Also 77/0 → 0xFF r 0x4D, `dz`=1.
- **Handshake:** `start` pulsed in cycles 3–5 of a MUL → ignored and `busy` stays 1. Results from earlier ops hold until the next `done`.
- **Reset:** `rst_n` low in cycle 4 of a DIV → all outputs 0 at once, no `done`. A new ADD after release completes correctly.
